// File: rtl/histogram_cdf_engine_if.sv
// Command handshake and bin-RAM bus shared by the histogram/CDF engine and its host.
// master = host side (issues commands, owns the RAM), slave = engine side.
interface histogram_cdf_engine_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COUNT_WIDTH = 17,
    parameter int CH_W        = 2
);
    logic                          cmd_valid;
    logic [1:0]                    cmd_op;
    logic [CH_W-1:0]               cmd_channel;
    logic                          cmd_ready;
    logic                          done;
    logic [1:0]                    done_op;
    logic [CH_W+PIXEL_WIDTH-1:0]   ram_addr;
    logic                          ram_ce;
    logic                          ram_we;
    logic [COUNT_WIDTH-1:0]        ram_wdata;
    logic [COUNT_WIDTH-1:0]        ram_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_channel, ram_rdata,
        input  cmd_ready, done, done_op, ram_addr, ram_ce, ram_we, ram_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_channel, ram_rdata,
        output cmd_ready, done, done_op, ram_addr, ram_ce, ram_we, ram_wdata
    );
endinterface

// File: rtl/histogram_cdf_engine.sv
// Multi-channel histogram/CDF engine: clears, accumulates a pixel table into, or prefix-sums
// a channel's bin RAM in place, reporting the first non-zero CDF value and the CDF total.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for a command, cmd_ready high
//   S_CLEAR | writing 0 to one bin per cycle
//   S_H_RD  | reading the bin selected by the current pixel
//   S_H_WR  | writing that bin back incremented (saturating)
//   S_C_RD  | reading bin b of the running prefix sum
//   S_C_WR  | writing the accumulated sum back to bin b
//   S_FIN   | one-cycle done pulse, then back to idle
module histogram_cdf_engine #(
    parameter int PIXEL_WIDTH = 8,
    parameter int TABLE_SIZE  = 64,
    parameter int DC_OFFSET   = 128,
    parameter int CHANNELS    = 3,
    parameter int COUNT_WIDTH = 17,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [TABLE_SIZE*PIXEL_WIDTH-1:0] image_table,
    histogram_cdf_engine_if.slave             bus,
    output logic [COUNT_WIDTH-1:0]            cdf_min,
    output logic [COUNT_WIDTH-1:0]            cdf_total
);

    localparam int TI_W = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
    localparam logic [PIXEL_WIDTH-1:0] DC       = PIXEL_WIDTH'(DC_OFFSET);
    localparam logic [TI_W-1:0]        LAST_PIX = TI_W'(TABLE_SIZE - 1);
    localparam logic [PIXEL_WIDTH-1:0] LAST_BIN = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_H_RD,
        S_H_WR,
        S_C_RD,
        S_C_WR,
        S_FIN
    } state_t;

    state_t                                   state;
    state_t                                   state_nx;
    logic [1:0]                               op_q;
    logic [CH_W-1:0]                          ch_q;
    logic [TABLE_SIZE-1:0][PIXEL_WIDTH-1:0]   table_q;
    logic [PIXEL_WIDTH-1:0]                   bin_idx;
    logic [TI_W-1:0]                          pix_idx;
    logic [COUNT_WIDTH-1:0]                   acc;
    logic                                     min_set;

    logic                                     accept;
    logic                                     ch_ok;
    logic [PIXEL_WIDTH-1:0]                   pix_bin;
    logic [COUNT_WIDTH-1:0]                   hist_inc;
    logic [COUNT_WIDTH-1:0]                   cdf_sum;

    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [COUNT_WIDTH-1:0] b);
        logic [COUNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : s[COUNT_WIDTH-1:0];
    endfunction

    assign accept   = (state == S_IDLE) && bus.cmd_valid;
    assign ch_ok    = (int'(bus.cmd_channel) < CHANNELS);
    assign pix_bin  = table_q[pix_idx] + DC;
    assign hist_inc = sat_add(bus.ram_rdata, COUNT_WIDTH'(1));
    assign cdf_sum  = sat_add(acc, bus.ram_rdata);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        bus.done      = 1'b0;
        bus.done_op   = 2'd0;
        bus.ram_ce    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        case (state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    // unknown channels complete as a NOP so the host still sees done
                    if (!ch_ok) begin
                        state_nx = S_FIN;
                    end else begin
                        case (bus.cmd_op)
                            2'd0:    state_nx = S_CLEAR;
                            2'd1:    state_nx = S_H_RD;
                            2'd2:    state_nx = S_C_RD;
                            default: state_nx = S_FIN;
                        endcase
                    end
                end
            end
            S_CLEAR: begin
                bus.ram_ce   = 1'b1;
                bus.ram_we   = 1'b1;
                bus.ram_addr = {ch_q, bin_idx};
                if (bin_idx == LAST_BIN) state_nx = S_FIN;
            end
            S_H_RD: begin
                bus.ram_ce   = 1'b1;
                bus.ram_addr = {ch_q, pix_bin};
                state_nx     = S_H_WR;
            end
            S_H_WR: begin
                bus.ram_ce    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = {ch_q, pix_bin};
                bus.ram_wdata = hist_inc;
                state_nx      = (pix_idx == LAST_PIX) ? S_FIN : S_H_RD;
            end
            S_C_RD: begin
                bus.ram_ce   = 1'b1;
                bus.ram_addr = {ch_q, bin_idx};
                state_nx     = S_C_WR;
            end
            S_C_WR: begin
                bus.ram_ce    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = {ch_q, bin_idx};
                bus.ram_wdata = cdf_sum;
                state_nx      = (bin_idx == LAST_BIN) ? S_FIN : S_C_RD;
            end
            S_FIN: begin
                bus.done    = 1'b1;
                bus.done_op = op_q;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= 2'd0;
            ch_q      <= '0;
            table_q   <= '0;
            bin_idx   <= '0;
            pix_idx   <= '0;
            acc       <= '0;
            min_set   <= 1'b0;
            cdf_min   <= '0;
            cdf_total <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.cmd_op;
                ch_q    <= bus.cmd_channel;
                table_q <= image_table;
                bin_idx <= '0;
                pix_idx <= '0;
                if (bus.cmd_op == 2'd2 && ch_ok) begin
                    acc     <= '0;
                    min_set <= 1'b0;
                    cdf_min <= '0;
                end
            end
            case (state)
                S_CLEAR: bin_idx <= bin_idx + 1'b1;
                S_H_WR:  pix_idx <= pix_idx + 1'b1;
                S_C_WR: begin
                    acc     <= cdf_sum;
                    bin_idx <= bin_idx + 1'b1;
                    if (!min_set && bus.ram_rdata != '0) begin
                        cdf_min <= cdf_sum;
                        min_set <= 1'b1;
                    end
                    if (bin_idx == LAST_BIN) cdf_total <= cdf_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_cdf_engine.sv
// Bench for histogram_cdf_engine: directed commands against a bin-count model of the RAM,
// with a per-cycle compare of handshake, RAM write stream and CDF results.
module tb_histogram_cdf_engine;

    localparam int MAXV = 131071;

    typedef struct packed {
        logic [9:0]  a;
        logic [16:0] d;
    } wr_t;

    logic         clk;
    logic         rst;
    logic [511:0] image_table;
    logic [16:0]  cdf_min;
    logic [16:0]  cdf_total;

    histogram_cdf_engine_if #(.PIXEL_WIDTH(8), .COUNT_WIDTH(17), .CH_W(2)) bus ();

    histogram_cdf_engine dut (
        .clk        (clk),
        .rst        (rst),
        .image_table(image_table),
        .bus        (bus),
        .cdf_min    (cdf_min),
        .cdf_total  (cdf_total)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cnt = 0;
    int          done_cnt = 0;
    int          accept_cyc = 0;
    int          exp_done_cyc = 0;
    int          last_done_cyc = -1;
    logic [1:0]  cur_op = 2'd0;
    bit          cur_cdf = 0;
    int unsigned exp_mem [0:767];
    int unsigned nxt_min = 0, nxt_total = 0;
    int unsigned exp_min = 0, exp_total = 0;
    wr_t         wq [$];

    logic [16:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [16:0] pre_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // bin RAM: registered read, write-through not needed since reads and writes alternate
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (bus.ram_ce) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int unsigned sat(input int unsigned a, input int unsigned b);
        return (a + b > MAXV) ? MAXV : a + b;
    endfunction

    function automatic void push(input int addr, input int unsigned data);
        wr_t w;
        w.a = 10'(addr);
        w.d = 17'(data);
        wq.push_back(w);
    endfunction

    // compare process: runs every falling edge while out of reset
    initial begin
        bit  pend, exp_done;
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wq.delete();
                done_cnt  = accept_cnt;
                exp_min   = 0;
                exp_total = 0;
            end else begin
                pend     = (accept_cnt != done_cnt);
                exp_done = pend && (cyc == exp_done_cyc);
                chk("cmd_ready", 32'(bus.cmd_ready), 32'(!pend));
                chk("done", 32'(bus.done), 32'(exp_done));
                if (exp_done) chk("done_op", 32'(bus.done_op), 32'(cur_op));
                chk("ram_ce", 32'(bus.ram_ce), 32'(pend && cyc < exp_done_cyc));
                if (bus.ram_ce && bus.ram_we) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_write_addr", 32'(bus.ram_addr), 32'hFFFF_FFFF);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_addr", 32'(bus.ram_addr), 32'(w.a));
                        chk("wr_data", 32'(bus.ram_wdata), 32'(w.d));
                    end
                end
                if (!(pend && cur_cdf)) begin
                    chk("cdf_min", 32'(cdf_min), exp_min);
                    chk("cdf_total", 32'(cdf_total), exp_total);
                end
                if (exp_done) begin
                    chk("writes_left_at_done", 32'(wq.size()), 32'd0);
                    if (cur_cdf) begin
                        exp_min   = nxt_min;
                        exp_total = nxt_total;
                    end
                    last_done_cyc = cyc;
                    done_cnt++;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [1:0] ch, input logic [511:0] tbl);
        int          work, base, bin;
        int unsigned acc, mn, v;
        bit          found;
        work = 0;
        base = int'(ch) * 256;
        if (ch < 2'd3) begin
            case (op)
                2'd0: begin
                    work = 256;
                    for (int b = 0; b < 256; b++) begin
                        exp_mem[base+b] = 0;
                        push(base + b, 0);
                    end
                end
                2'd1: begin
                    work = 128;
                    for (int k = 0; k < 64; k++) begin
                        bin = (int'(tbl[k*8 +: 8]) + 128) % 256;
                        exp_mem[base+bin] = sat(exp_mem[base+bin], 1);
                        push(base + bin, exp_mem[base+bin]);
                    end
                end
                2'd2: begin
                    work  = 512;
                    acc   = 0;
                    mn    = 0;
                    found = 0;
                    for (int b = 0; b < 256; b++) begin
                        v   = exp_mem[base+b];
                        acc = sat(acc, v);
                        if (v != 0 && !found) begin
                            found = 1;
                            mn    = acc;
                        end
                        exp_mem[base+b] = acc;
                        push(base + b, acc);
                    end
                    nxt_min   = mn;
                    nxt_total = acc;
                end
                default: work = 0;
            endcase
        end
        @(negedge clk);
        image_table     = tbl;
        bus.cmd_op      = op;
        bus.cmd_channel = ch;
        bus.cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        image_table   = ~tbl;
        cur_op        = op;
        cur_cdf       = (op == 2'd2) && (ch < 2'd3);
        accept_cyc    = cyc;
        exp_done_cyc  = cyc + work;
        accept_cnt++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1000; i++) begin
            if (accept_cnt == done_cnt) break;
            @(negedge clk);
        end
        chk("done_timeout", 32'(accept_cnt != done_cnt), 32'd0);
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] op, input logic [1:0] ch, input logic [511:0] tbl);
        issue(op, ch, tbl);
        wait_done();
    endtask

    logic [511:0] t;

    initial begin
        rst             = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'd3;
        bus.cmd_channel = 2'd0;
        image_table     = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ram_ce", 32'(bus.ram_ce), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_cdf_total", 32'(cdf_total), 32'd0);
        #1 rst = 1'b1;

        // T1: clear ch1, done 256 cycles after the accept edge (257th cycle)
        run(2'd0, 2'd1, '0);
        chk("t1_done_latency", 32'(last_done_cyc - accept_cyc), 32'd256);
        run(2'd0, 2'd0, '0);
        run(2'd0, 2'd2, '0);

        // T2: all pixels 0x80 land in bin 0
        t = {64{8'h80}};
        run(2'd1, 2'd0, t);
        chk("t2_bin0", 32'(mem[0]), 32'd64);
        chk("t2_bin1", 32'(mem[1]), 32'd0);

        // T3: pixel k = k-32 -> bins 96..159, twice
        run(2'd0, 2'd0, '0);
        for (int k = 0; k < 64; k++) t[k*8 +: 8] = 8'(k - 32);
        run(2'd1, 2'd0, t);
        chk("t3_bin96_once", 32'(mem[96]), 32'd1);
        run(2'd1, 2'd0, t);
        chk("t3_bin159_twice", 32'(mem[159]), 32'd2);

        // T4: CDF of ch0
        run(2'd2, 2'd0, '0);
        chk("t4_bin95", 32'(mem[95]), 32'd0);
        chk("t4_bin96", 32'(mem[96]), 32'd2);
        chk("t4_bin159", 32'(mem[159]), 32'd128);
        chk("t4_bin255", 32'(mem[255]), 32'd128);
        chk("t4_cdf_min", 32'(cdf_min), 32'd2);
        chk("t4_cdf_total", 32'(cdf_total), 32'd128);

        // all-zero channel CDF, and a NOP that must not disturb held results
        run(2'd2, 2'd1, '0);
        chk("zero_ch_cdf_total", 32'(cdf_total), 32'd0);
        run(2'd3, 2'd0, '0);
        chk("nop_latency", 32'(last_done_cyc - accept_cyc), 32'd0);
        run(2'd0, 2'd3, '0);

        // clustered pixels wrapping around bin 255/0 with many duplicates on ch2,
        // while a busy-time command and table change are presented and must be ignored
        for (int k = 0; k < 64; k++) t[k*8 +: 8] = 8'($urandom_range(0, 15) + 120);
        issue(2'd1, 2'd2, t);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.cmd_valid   = 1'b1;
            bus.cmd_op      = 2'd0;
            bus.cmd_channel = 2'd2;
            image_table     = {16{$urandom}};
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_done();
        run(2'd2, 2'd2, '0);
        chk("ch0_untouched", 32'(mem[96]), 32'd2);

        // T5: saturation of a preloaded bin, then a saturating CDF
        run(2'd0, 2'd0, '0);
        @(negedge clk);
        pre_en     = 1'b1;
        pre_addr   = 10'd5;
        pre_data   = 17'h1FFFF;
        exp_mem[5] = MAXV;
        @(negedge clk);
        pre_en = 1'b0;
        t = {{63{8'h86}}, 8'h85};
        run(2'd1, 2'd0, t);
        chk("t5_bin5_sat", 32'(mem[5]), 32'h1FFFF);
        chk("t5_bin6", 32'(mem[6]), 32'd63);
        run(2'd2, 2'd0, '0);
        chk("t5_cdf_total_sat", 32'(cdf_total), 32'h1FFFF);

        // T6: reset while the CDF of ch2 is reading bin 40
        issue(2'd2, 2'd2, '0);
        while (cyc < accept_cyc + 80) @(negedge clk);
        chk("t6_in_cdf_rd", 32'(bus.ram_addr), 32'h228);
        rst = 1'b0;
        #1;
        chk("t6_rst_done", 32'(bus.done), 32'd0);
        chk("t6_rst_ram_ce", 32'(bus.ram_ce), 32'd0);
        chk("t6_rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("t6_rst_wdata", 32'(bus.ram_wdata), 32'd0);
        chk("t6_rst_cdf_min", 32'(cdf_min), 32'd0);
        chk("t6_rst_cdf_total", 32'(cdf_total), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);

        // recovery after abort
        run(2'd0, 2'd2, '0);
        for (int k = 0; k < 64; k++) t[k*8 +: 8] = 8'($urandom_range(0, 255));
        run(2'd1, 2'd2, t);
        run(2'd2, 2'd2, '0);
        chk("recover_total", 32'(cdf_total), 32'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
